// File: rtl/tcp_server_mc_pkg.sv
// Shared types for the multi-connection TCP server control path:
// per-slot state encoding, header flag bundle and response kinds.
package tcp_server_mc_pkg;

  typedef enum logic [2:0] {
    ST_CLOSED      = 3'd0,
    ST_LISTEN      = 3'd1,
    ST_SYN_RCVD    = 3'd2,
    ST_ESTABLISHED = 3'd3,
    ST_FLUSH       = 3'd4,
    ST_RST_RCVD    = 3'd5
  } conn_state_t;

  typedef struct packed {
    logic syn;
    logic ack;
    logic fin;
    logic rst;
  } tcp_flags_t;

  typedef enum logic [2:0] {
    RSP_NONE   = 3'd0,
    RSP_SYNACK = 3'd1,
    RSP_ACK    = 3'd2,
    RSP_FINACK = 3'd3,
    RSP_RST    = 3'd4
  } resp_kind_t;

  function automatic tcp_flags_t resp_flags(input resp_kind_t kind);
    tcp_flags_t f;
    f = '0;
    case (kind)
      RSP_SYNACK: begin f.syn = 1'b1; f.ack = 1'b1; end
      RSP_ACK:    f.ack = 1'b1;
      RSP_FINACK: begin f.fin = 1'b1; f.ack = 1'b1; end
      RSP_RST:    f.rst = 1'b1;
      default:    f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/tcp_conn_slot.sv
// One server connection slot: state, rcv_nxt, snd_nxt and flush timer, plus the
// response each candidate rx segment or host command would produce this cycle.
module tcp_conn_slot
  import tcp_server_mc_pkg::*;
#(
  parameter int unsigned SLOT          = 0,
  parameter int unsigned SEQ_W         = 32,
  parameter int unsigned LEN_W         = 16,
  parameter logic [31:0] ISN_BASE      = 32'h1000_0000,
  parameter logic [31:0] ISN_STRIDE    = 32'h0100_0000,
  parameter int unsigned FLUSH_CYCLES  = 8,
  parameter int unsigned AUTO_RELISTEN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_en,
  input  tcp_flags_t       rx_flags,
  input  logic [SEQ_W-1:0] rx_seq,
  input  logic [SEQ_W-1:0] rx_ack_num,
  input  logic [LEN_W-1:0] rx_len,
  input  logic             cmd_en,
  input  logic             cmd_close,
  output conn_state_t      state,
  output resp_kind_t       rx_kind,
  output logic [SEQ_W-1:0] rx_rsp_seq,
  output logic [SEQ_W-1:0] rx_rsp_ack,
  output resp_kind_t       cmd_kind,
  output logic [SEQ_W-1:0] cmd_rsp_seq,
  output logic [SEQ_W-1:0] cmd_rsp_ack
);

  localparam int unsigned      CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [63:0]      ISN_WIDE   = 64'(ISN_BASE) + 64'(ISN_STRIDE) * 64'(SLOT);
  localparam logic [SEQ_W-1:0] ISN        = SEQ_W'(ISN_WIDE);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam conn_state_t      EXIT_ST    = (AUTO_RELISTEN != 0) ? ST_LISTEN : ST_CLOSED;

  logic [SEQ_W-1:0] rcv_nxt, snd_nxt, len_ext;
  logic [CNT_W-1:0] flush_cnt, n_cnt;
  conn_state_t      rx_state, cmd_state, n_state;
  logic [SEQ_W-1:0] rx_rcv, rx_snd, cmd_snd, n_rcv, n_snd;

  assign len_ext = SEQ_W'(rx_len);

  always_comb begin
    rx_kind    = RSP_NONE;
    rx_rsp_seq = rx_ack_num;
    rx_rsp_ack = '0;
    rx_state   = state;
    rx_rcv     = rcv_nxt;
    rx_snd     = snd_nxt;
    case (state)
      ST_CLOSED: if (!rx_flags.rst) rx_kind = RSP_RST;
      ST_LISTEN: begin
        if (rx_flags.syn && !rx_flags.ack && !rx_flags.rst) begin
          rx_state   = ST_SYN_RCVD;
          rx_rcv     = rx_seq + 1'b1;
          rx_snd     = ISN + 1'b1;
          rx_kind    = RSP_SYNACK;
          rx_rsp_seq = ISN;
          rx_rsp_ack = rx_seq + 1'b1;
        end else if (rx_flags.ack) begin
          rx_kind = RSP_RST;
        end
      end
      ST_SYN_RCVD: begin
        if (rx_flags.rst) rx_state = ST_RST_RCVD;
        else if (rx_flags.ack) begin
          if (rx_ack_num == snd_nxt) rx_state = ST_ESTABLISHED;
          else                       rx_kind  = RSP_RST;
        end
      end
      ST_ESTABLISHED: begin
        rx_rsp_seq = snd_nxt;
        rx_rsp_ack = rcv_nxt;
        if (rx_flags.rst) begin
          rx_state = ST_RST_RCVD;
        end else if (rx_seq != rcv_nxt) begin
          rx_kind = RSP_ACK;
        end else if (rx_flags.fin) begin
          rx_rcv     = rcv_nxt + len_ext + 1'b1;
          rx_rsp_ack = rcv_nxt + len_ext + 1'b1;
          rx_snd     = snd_nxt + 1'b1;
          rx_kind    = RSP_FINACK;
          rx_state   = ST_FLUSH;
        end else if (rx_len != '0) begin
          rx_rcv     = rcv_nxt + len_ext;
          rx_rsp_ack = rcv_nxt + len_ext;
          rx_kind    = RSP_ACK;
        end
      end
      ST_FLUSH: if (rx_flags.rst) rx_state = ST_RST_RCVD;
      default: ;
    endcase
  end

  always_comb begin
    cmd_kind    = RSP_NONE;
    cmd_rsp_seq = snd_nxt;
    cmd_rsp_ack = '0;
    cmd_state   = state;
    cmd_snd     = snd_nxt;
    case (state)
      ST_CLOSED: if (!cmd_close) cmd_state = ST_LISTEN;
      ST_LISTEN: if (cmd_close) cmd_state = ST_CLOSED;
      ST_SYN_RCVD: if (cmd_close) begin
        cmd_kind  = RSP_RST;
        cmd_state = ST_CLOSED;
      end
      ST_ESTABLISHED: if (cmd_close) begin
        cmd_kind    = RSP_FINACK;
        cmd_rsp_ack = rcv_nxt;
        cmd_snd     = snd_nxt + 1'b1;
        cmd_state   = ST_FLUSH;
      end
      default: ;
    endcase
  end

  // rx and cmd never target the same slot in one cycle; timed exits from
  // FLUSH/RST_RCVD apply unless an accepted segment moved the slot elsewhere.
  always_comb begin
    n_state = state;
    n_rcv   = rcv_nxt;
    n_snd   = snd_nxt;
    if (rx_en) begin
      n_state = rx_state;
      n_rcv   = rx_rcv;
      n_snd   = rx_snd;
    end else if (cmd_en) begin
      n_state = cmd_state;
      n_snd   = cmd_snd;
    end
    if (state == ST_FLUSH && n_state == ST_FLUSH && flush_cnt == '0) n_state = EXIT_ST;
    if (state == ST_RST_RCVD) n_state = EXIT_ST;

    n_cnt = flush_cnt;
    if (n_state == ST_FLUSH && state != ST_FLUSH)      n_cnt = FLUSH_LOAD;
    else if (state == ST_FLUSH && flush_cnt != '0)     n_cnt = flush_cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_CLOSED;
      rcv_nxt   <= '0;
      snd_nxt   <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= n_state;
      rcv_nxt   <= n_rcv;
      snd_nxt   <= n_snd;
      flush_cnt <= n_cnt;
    end
  end

endmodule

// File: rtl/tcp_server_mc.sv
// Multi-connection TCP server control: routes rx segments and host commands to
// per-slot FSMs and registers the single winning response header.
module tcp_server_mc
  import tcp_server_mc_pkg::*;
#(
  parameter int unsigned NUM_CONN      = 4,
  parameter int unsigned SEQ_W         = 32,
  parameter int unsigned LEN_W         = 16,
  parameter logic [31:0] ISN_BASE      = 32'h1000_0000,
  parameter logic [31:0] ISN_STRIDE    = 32'h0100_0000,
  parameter int unsigned FLUSH_CYCLES  = 8,
  parameter int unsigned AUTO_RELISTEN = 1,
  localparam int unsigned CONN_W       = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CONN_W-1:0]     cmd_conn,
  input  logic                  cmd_close,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [CONN_W-1:0]     rx_conn,
  input  logic                  rx_syn,
  input  logic                  rx_ack,
  input  logic                  rx_fin,
  input  logic                  rx_rst,
  input  logic [SEQ_W-1:0]      rx_seq,
  input  logic [SEQ_W-1:0]      rx_ack_num,
  input  logic [LEN_W-1:0]      rx_len,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [CONN_W-1:0]     tx_conn,
  output logic                  tx_syn,
  output logic                  tx_ack,
  output logic                  tx_fin,
  output logic                  tx_rst,
  output logic [SEQ_W-1:0]      tx_seq,
  output logic [SEQ_W-1:0]      tx_ack_num,
  output logic [3*NUM_CONN-1:0] conn_state
);

  tcp_flags_t       rx_flags;
  conn_state_t      slot_state   [NUM_CONN];
  resp_kind_t       slot_rx_kind [NUM_CONN];
  resp_kind_t       slot_cmd_kind[NUM_CONN];
  logic [SEQ_W-1:0] slot_rx_seq  [NUM_CONN];
  logic [SEQ_W-1:0] slot_rx_ack  [NUM_CONN];
  logic [SEQ_W-1:0] slot_cmd_seq [NUM_CONN];
  logic [SEQ_W-1:0] slot_cmd_ack [NUM_CONN];

  resp_kind_t rx_sel_kind, cmd_sel_kind;
  logic       rx_fire, cmd_fire, rx_wants_tx, cmd_wants_tx;

  assign rx_flags     = '{syn: rx_syn, ack: rx_ack, fin: rx_fin, rst: rx_rst};
  assign rx_sel_kind  = slot_rx_kind[rx_conn];
  assign cmd_sel_kind = slot_cmd_kind[cmd_conn];
  assign rx_wants_tx  = (rx_sel_kind != RSP_NONE);
  assign cmd_wants_tx = (cmd_sel_kind != RSP_NONE);

  assign rx_ready  = !tx_valid || tx_ready;
  assign rx_fire   = rx_valid && rx_ready;
  // A command stalls behind an rx segment to its own slot, or behind any rx
  // segment that claims the tx register in the same cycle.
  assign cmd_ready = rx_ready
                  && !(rx_valid && (rx_conn == cmd_conn))
                  && !(rx_valid && rx_wants_tx && cmd_wants_tx);
  assign cmd_fire  = cmd_valid && cmd_ready;

  for (genvar k = 0; k < NUM_CONN; k++) begin : g_slot
    tcp_conn_slot #(
      .SLOT          (k),
      .SEQ_W         (SEQ_W),
      .LEN_W         (LEN_W),
      .ISN_BASE      (ISN_BASE),
      .ISN_STRIDE    (ISN_STRIDE),
      .FLUSH_CYCLES  (FLUSH_CYCLES),
      .AUTO_RELISTEN (AUTO_RELISTEN)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .rx_en       (rx_fire && (rx_conn == CONN_W'(k))),
      .rx_flags    (rx_flags),
      .rx_seq      (rx_seq),
      .rx_ack_num  (rx_ack_num),
      .rx_len      (rx_len),
      .cmd_en      (cmd_fire && (cmd_conn == CONN_W'(k))),
      .cmd_close   (cmd_close),
      .state       (slot_state[k]),
      .rx_kind     (slot_rx_kind[k]),
      .rx_rsp_seq  (slot_rx_seq[k]),
      .rx_rsp_ack  (slot_rx_ack[k]),
      .cmd_kind    (slot_cmd_kind[k]),
      .cmd_rsp_seq (slot_cmd_seq[k]),
      .cmd_rsp_ack (slot_cmd_ack[k])
    );
  end

  always_comb begin
    conn_state = '0;
    for (int unsigned k = 0; k < NUM_CONN; k++) conn_state[3*k +: 3] = slot_state[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid   <= 1'b0;
      tx_conn    <= '0;
      tx_syn     <= 1'b0;
      tx_ack     <= 1'b0;
      tx_fin     <= 1'b0;
      tx_rst     <= 1'b0;
      tx_seq     <= '0;
      tx_ack_num <= '0;
    end else if (rx_ready) begin
      if (rx_fire && rx_wants_tx) begin
        tx_valid                         <= 1'b1;
        tx_conn                          <= rx_conn;
        {tx_syn, tx_ack, tx_fin, tx_rst} <= resp_flags(rx_sel_kind);
        tx_seq                           <= slot_rx_seq[rx_conn];
        tx_ack_num                       <= slot_rx_ack[rx_conn];
      end else if (cmd_fire && cmd_wants_tx) begin
        tx_valid                         <= 1'b1;
        tx_conn                          <= cmd_conn;
        {tx_syn, tx_ack, tx_fin, tx_rst} <= resp_flags(cmd_sel_kind);
        tx_seq                           <= slot_cmd_seq[cmd_conn];
        tx_ack_num                       <= slot_cmd_ack[cmd_conn];
      end else begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tcp_server_mc.sv
// Directed bench for tcp_server_mc: handshake, data, close/flush, wrap,
// backpressure, arbitration and reset, with hand-computed expectations.
module tb_tcp_server_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_close = 1'b0;
  logic [1:0]  cmd_conn = '0;
  logic        rx_valid = 1'b0, rx_syn = 1'b0, rx_ack = 1'b0, rx_fin = 1'b0, rx_rst = 1'b0;
  logic [1:0]  rx_conn = '0;
  logic [31:0] rx_seq = '0, rx_ack_num = '0;
  logic [15:0] rx_len = '0;
  logic        tx_ready = 1'b1;

  logic        cmd_ready, rx_ready, tx_valid, tx_syn, tx_ack, tx_fin, tx_rst;
  logic [1:0]  tx_conn;
  logic [31:0] tx_seq, tx_ack_num;
  logic [11:0] conn_state;

  logic        nr_cmd_ready, nr_rx_ready, nr_tx_valid, nr_tx_syn, nr_tx_ack, nr_tx_fin, nr_tx_rst;
  logic [1:0]  nr_tx_conn;
  logic [31:0] nr_tx_seq, nr_tx_ack_num;
  logic [11:0] nr_conn_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tcp_server_mc #(.NUM_CONN(4), .AUTO_RELISTEN(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_conn(cmd_conn), .cmd_close(cmd_close),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_conn(rx_conn),
    .rx_syn(rx_syn), .rx_ack(rx_ack), .rx_fin(rx_fin), .rx_rst(rx_rst),
    .rx_seq(rx_seq), .rx_ack_num(rx_ack_num), .rx_len(rx_len),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_conn(tx_conn),
    .tx_syn(tx_syn), .tx_ack(tx_ack), .tx_fin(tx_fin), .tx_rst(tx_rst),
    .tx_seq(tx_seq), .tx_ack_num(tx_ack_num), .conn_state(conn_state)
  );

  tcp_server_mc #(.NUM_CONN(4), .AUTO_RELISTEN(0)) dut_nr (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(nr_cmd_ready), .cmd_conn(cmd_conn), .cmd_close(cmd_close),
    .rx_valid(rx_valid), .rx_ready(nr_rx_ready), .rx_conn(rx_conn),
    .rx_syn(rx_syn), .rx_ack(rx_ack), .rx_fin(rx_fin), .rx_rst(rx_rst),
    .rx_seq(rx_seq), .rx_ack_num(rx_ack_num), .rx_len(rx_len),
    .tx_valid(nr_tx_valid), .tx_ready(tx_ready), .tx_conn(nr_tx_conn),
    .tx_syn(nr_tx_syn), .tx_ack(nr_tx_ack), .tx_fin(nr_tx_fin), .tx_rst(nr_tx_rst),
    .tx_seq(nr_tx_seq), .tx_ack_num(nr_tx_ack_num), .conn_state(nr_conn_state)
  );

  function automatic logic [2:0] slot_st(input logic [11:0] cs, input int k);
    return cs[3*k +: 3];
  endfunction

  function automatic logic [4:0] txf();
    return {tx_valid, tx_syn, tx_ack, tx_fin, tx_rst};
  endfunction

  // flags argument order: {syn, ack, fin, rst}
  task automatic drive_rx(input logic [1:0] conn, input logic [3:0] f,
                          input logic [31:0] seq, input logic [31:0] ackn, input logic [15:0] len);
    rx_conn = conn;
    {rx_syn, rx_ack, rx_fin, rx_rst} = f;
    rx_seq = seq; rx_ack_num = ackn; rx_len = len;
    rx_valid = 1'b1;
  endtask

  task automatic rx_seg(input logic [1:0] conn, input logic [3:0] f,
                        input logic [31:0] seq, input logic [31:0] ackn, input logic [15:0] len);
    @(negedge clk);
    drive_rx(conn, f, seq, ackn, len);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] conn, input logic close);
    @(negedge clk);
    cmd_conn = conn; cmd_close = close; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (conn_state !== 12'h000) begin errors++; $display("FAIL reset_state got %h want 000", conn_state); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    checks++; if ({tx_seq, tx_ack_num} !== 64'h0) begin errors++; $display("FAIL reset_tx_nums got %h want 0", {tx_seq, tx_ack_num}); end
    checks++; if ({rx_ready, cmd_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready got %b want 11", {rx_ready, cmd_ready}); end
    rst = 1'b0;
  endtask

  task automatic test_closed_rst;
    rx_seg(2'd0, 4'b0100, 32'd5, 32'hDEAD_BEEF, 16'd0);
    checks++; if (txf() !== 5'b10001) begin errors++; $display("FAIL closed_rst_flags got %b want 10001", txf()); end
    checks++; if (tx_seq !== 32'hDEAD_BEEF) begin errors++; $display("FAIL closed_rst_seq got %h want deadbeef", tx_seq); end
    checks++; if (tx_conn !== 2'd0) begin errors++; $display("FAIL closed_rst_conn got %0d want 0", tx_conn); end
  endtask

  task automatic test_arbitration;
    @(negedge clk);
    cmd_conn = 2'd1; cmd_close = 1'b0; cmd_valid = 1'b1;
    drive_rx(2'd0, 4'b0100, 32'd0, 32'h55, 16'd0);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL arb_diff_slot_ready got %b want 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0; rx_valid = 1'b0;
    checks++; if (slot_st(conn_state, 1) !== 3'd1) begin errors++; $display("FAIL arb_open_state got %0d want 1", slot_st(conn_state, 1)); end
    checks++; if (txf() !== 5'b10001 || tx_seq !== 32'h55 || tx_conn !== 2'd0) begin
      errors++; $display("FAIL arb_rx_rst got %b/%h/%0d want 10001/55/0", txf(), tx_seq, tx_conn); end

    rx_seg(2'd1, 4'b1000, 32'd0, 32'd0, 16'd0);
    checks++; if (slot_st(conn_state, 1) !== 3'd2) begin errors++; $display("FAIL arb_synrcvd got %0d want 2", slot_st(conn_state, 1)); end
    checks++; if (txf() !== 5'b11100 || tx_seq !== 32'h1100_0000 || tx_ack_num !== 32'd1) begin
      errors++; $display("FAIL arb_synack got %b/%h/%h want 11100/11000000/1", txf(), tx_seq, tx_ack_num); end

    @(negedge clk);
    cmd_conn = 2'd1; cmd_close = 1'b1; cmd_valid = 1'b1;
    drive_rx(2'd0, 4'b0100, 32'd0, 32'h66, 16'd0);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL arb_both_tx_ready got %b want 0", cmd_ready); end
    cmd_conn = 2'd0;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL arb_same_slot_ready got %b want 0", cmd_ready); end
    cmd_conn = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0; rx_valid = 1'b0; cmd_close = 1'b0;
    checks++; if (slot_st(conn_state, 1) !== 3'd2) begin errors++; $display("FAIL arb_cmd_held got %0d want 2", slot_st(conn_state, 1)); end
    checks++; if (txf() !== 5'b10001 || tx_seq !== 32'h66) begin
      errors++; $display("FAIL arb_rx_wins got %b/%h want 10001/66", txf(), tx_seq); end
  endtask

  task automatic test_async_reset;
    rx_seg(2'd0, 4'b0100, 32'd0, 32'h77, 16'd0);
    #2 rst = 1'b1;
    #1;
    checks++; if (conn_state !== 12'h000 || nr_conn_state !== 12'h000) begin
      errors++; $display("FAIL async_rst_state got %h/%h want 000", conn_state, nr_conn_state); end
    checks++; if (tx_valid !== 1'b0 || tx_seq !== 32'h0 || tx_rst !== 1'b0) begin
      errors++; $display("FAIL async_rst_tx got %b/%h/%b want 0/0/0", tx_valid, tx_seq, tx_rst); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_handshake;
    cmd(2'd2, 1'b0);
    checks++; if (slot_st(conn_state, 2) !== 3'd1) begin errors++; $display("FAIL hs_listen got %0d want 1", slot_st(conn_state, 2)); end
    rx_seg(2'd2, 4'b1000, 32'd100, 32'd0, 16'd0);
    checks++; if (txf() !== 5'b11100 || tx_conn !== 2'd2) begin errors++; $display("FAIL hs_synack_flags got %b/%0d want 11100/2", txf(), tx_conn); end
    checks++; if (tx_seq !== 32'h1200_0000 || tx_ack_num !== 32'd101) begin
      errors++; $display("FAIL hs_synack_nums got %h/%h want 12000000/65", tx_seq, tx_ack_num); end
    rx_seg(2'd2, 4'b0100, 32'd101, 32'h1200_0001, 16'd0);
    checks++; if (slot_st(conn_state, 2) !== 3'd3 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL hs_established got %0d/%b want 3/0", slot_st(conn_state, 2), tx_valid); end
  endtask

  task automatic test_data;
    rx_seg(2'd2, 4'b0100, 32'd101, 32'h1200_0001, 16'd50);
    checks++; if (txf() !== 5'b10100 || tx_seq !== 32'h1200_0001 || tx_ack_num !== 32'd151) begin
      errors++; $display("FAIL data_ack got %b/%h/%0d want 10100/12000001/151", txf(), tx_seq, tx_ack_num); end
    rx_seg(2'd2, 4'b0100, 32'd300, 32'h1200_0001, 16'd10);
    checks++; if (txf() !== 5'b10100 || tx_ack_num !== 32'd151) begin
      errors++; $display("FAIL data_dupack got %b/%0d want 10100/151", txf(), tx_ack_num); end
  endtask

  task automatic test_close;
    int n;
    rx_seg(2'd2, 4'b0110, 32'd151, 32'h1200_0001, 16'd0);
    checks++; if (txf() !== 5'b10110 || tx_seq !== 32'h1200_0001 || tx_ack_num !== 32'd152) begin
      errors++; $display("FAIL close_finack got %b/%h/%0d want 10110/12000001/152", txf(), tx_seq, tx_ack_num); end
    n = 0;
    while (slot_st(conn_state, 2) == 3'd4 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n != 8) begin errors++; $display("FAIL flush_cycles got %0d want 8", n); end
    checks++; if (slot_st(conn_state, 2) !== 3'd1) begin errors++; $display("FAIL flush_relisten got %0d want 1", slot_st(conn_state, 2)); end
    checks++; if (slot_st(nr_conn_state, 2) !== 3'd0) begin errors++; $display("FAIL flush_closed got %0d want 0", slot_st(nr_conn_state, 2)); end
  endtask

  task automatic test_wrap;
    cmd(2'd1, 1'b0);
    rx_seg(2'd1, 4'b1000, 32'hFFFF_FFFF, 32'd0, 16'd0);
    checks++; if (txf() !== 5'b11100 || tx_seq !== 32'h1100_0000 || tx_ack_num !== 32'd0) begin
      errors++; $display("FAIL wrap_synack got %b/%h/%h want 11100/11000000/0", txf(), tx_seq, tx_ack_num); end
    rx_seg(2'd1, 4'b0100, 32'd0, 32'h1100_0001, 16'd0);
    checks++; if (slot_st(conn_state, 1) !== 3'd3) begin errors++; $display("FAIL wrap_est got %0d want 3", slot_st(conn_state, 1)); end
    rx_seg(2'd1, 4'b0100, 32'd0, 32'h1100_0001, 16'd4);
    checks++; if (txf() !== 5'b10100 || tx_ack_num !== 32'd4) begin
      errors++; $display("FAIL wrap_data got %b/%0d want 10100/4", txf(), tx_ack_num); end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    tx_ready = 1'b0;
    drive_rx(2'd1, 4'b0100, 32'd4, 32'h1100_0001, 16'd8);
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_ack_num !== 32'd12) begin
      errors++; $display("FAIL bp_first got %b/%0d want 1/12", tx_valid, tx_ack_num); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL bp_rx_ready got %b want 0", rx_ready); end
    drive_rx(2'd1, 4'b0100, 32'd12, 32'h1100_0001, 16'd2);
    repeat (3) @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_ack_num !== 32'd12 || tx_seq !== 32'h1100_0001 || txf() !== 5'b10100) begin
      errors++; $display("FAIL bp_stable got %b/%0d/%h want 1/12/11000001", tx_valid, tx_ack_num, tx_seq); end
    tx_ready = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    checks++; if (tx_valid !== 1'b1 || tx_ack_num !== 32'd14) begin
      errors++; $display("FAIL bp_second got %b/%0d want 1/14", tx_valid, tx_ack_num); end
    @(negedge clk);
  endtask

  task automatic test_rst_est;
    rx_seg(2'd1, 4'b0001, 32'd14, 32'd0, 16'd0);
    checks++; if (slot_st(conn_state, 1) !== 3'd5 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL rst_rcvd got %0d/%b want 5/0", slot_st(conn_state, 1), tx_valid); end
    @(negedge clk);
    checks++; if (slot_st(conn_state, 1) !== 3'd1 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL rst_relisten got %0d/%b want 1/0", slot_st(conn_state, 1), tx_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_closed_rst;
    test_arbitration;
    test_async_reset;
    test_handshake;
    test_data;
    test_close;
    test_wrap;
    test_backpressure;
    test_rst_est;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcp_server_mc.md
Name: tcp_server_mc

Overview:
- Multi-connection, parametrised successor to the single-connection TCP server control FSM. Tracks up to NUM_CONN independent server connections: per-slot state, rcv_nxt and snd_nxt.
- Consumes parsed inbound segment headers and emits response headers (SYN|ACK, ACK, FIN|ACK, RST) through a valid/ready port.
- Sits between the RX header parser and the TX header builder. Payload is handled elsewhere.

Parameters:
NUM_CONN, 4, number of connection slots (>=1)
SEQ_W, 32, sequence/ack number width
LEN_W, 16, segment payload length width
ISN_BASE, 32'h1000_0000, initial send sequence of slot 0 (truncated to SEQ_W)
ISN_STRIDE, 32'h0100_0000, ISN offset per slot; ISN(k) = ISN_BASE + k*ISN_STRIDE mod 2^SEQ_W
FLUSH_CYCLES, 8, cycles spent in FLUSH before leaving
AUTO_RELISTEN, 1, 1: FLUSH/RST_RCVD exit to LISTEN; 0: exit to CLOSED

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_conn  in  $clog2(NUM_CONN)  target slot
cmd_close  in  1  0=OPEN, 1=CLOSE
rx_valid  in  1  inbound segment valid
rx_ready  out  1  segment consumed when rx_valid&&rx_ready
rx_conn  in  $clog2(NUM_CONN)  slot selected by the upstream lookup
rx_syn, rx_ack, rx_fin, rx_rst  in  1 each  inbound flags
rx_seq  in  SEQ_W  inbound sequence number
rx_ack_num  in  SEQ_W  inbound ack number
rx_len  in  LEN_W  payload length
tx_valid  out  1  response valid
tx_ready  in  1  downstream accept
tx_conn  out  $clog2(NUM_CONN)  response slot
tx_syn, tx_ack, tx_fin, tx_rst  out  1 each  response flags
tx_seq, tx_ack_num  out  SEQ_W  response numbers
conn_state  out  3*NUM_CONN  packed per-slot state encoding

Behaviour:
- Reset (async, any time, including mid-handshake): all slots CLOSED; rcv_nxt, snd_nxt and flush counters 0; tx_valid 0; all tx fields 0.
- Single tx output register. rx_ready = !tx_valid || tx_ready.
- cmd_ready = rx_ready && !(rx_valid && rx_conn==cmd_conn). An rx segment to the same slot wins; the command waits.
- Each accepted rx segment or command updates its slot in the same cycle. Any response is registered, so tx_valid rises the next cycle (latency 1). tx fields stay stable while tx_valid && !tx_ready.
- A command and an rx segment to different slots may both be accepted in one cycle. If both want to transmit, the rx response wins and cmd_ready is held low for that cycle.
- States: CLOSED, LISTEN, SYN_RCVD, ESTABLISHED, FLUSH, RST_RCVD.
- CLOSED:
  - OPEN -> LISTEN.
  - Any rx without rst -> tx RST, seq=rx_ack_num.
- LISTEN:
  - rx syn && !ack && !rst -> SYN_RCVD; rcv_nxt=rx_seq+1; tx SYN|ACK, seq=ISN(k), ack=rcv_nxt; snd_nxt=ISN(k)+1.
  - rx with ack -> tx RST, seq=rx_ack_num.
  - Other rx dropped.
  - CLOSE -> CLOSED, no tx.
- SYN_RCVD:
  - rx rst -> RST_RCVD.
  - rx ack with rx_ack_num==snd_nxt -> ESTABLISHED, no tx.
  - rx ack mismatch -> tx RST, seq=rx_ack_num, stay.
  - CLOSE -> tx RST, seq=snd_nxt -> CLOSED.
- ESTABLISHED:
  - rx rst -> RST_RCVD, no tx.
  - In-order (rx_seq==rcv_nxt) with rx_fin -> rcv_nxt+=rx_len+1; tx FIN|ACK, seq=snd_nxt; snd_nxt+=1; -> FLUSH.
  - In-order, rx_len>0 -> rcv_nxt+=rx_len; tx ACK, seq=snd_nxt, ack=rcv_nxt.
  - Out-of-order -> tx duplicate ACK, ack=rcv_nxt, no update.
  - Zero-length in-order ACK: no tx.
  - CLOSE -> tx FIN|ACK; snd_nxt+=1; -> FLUSH.
- FLUSH:
  - Counter loads FLUSH_CYCLES-1 on entry and decrements each cycle. At 0, exits per AUTO_RELISTEN.
  - rx rst -> RST_RCVD.
  - Other rx dropped.
- RST_RCVD: one cycle, no tx, then exits per AUTO_RELISTEN.
- Commands with no listed transition are accepted and ignored.
- Arithmetic: all sequence arithmetic modulo 2^SEQ_W; rx_len is zero-extended.
- Encoding: CLOSED=0, LISTEN=1, SYN_RCVD=2, ESTABLISHED=3, FLUSH=4, RST_RCVD=5.

Decomposition:
- Package tcp_server_mc_pkg: state enum (3-bit, encoding above), tcp_flags_t struct {syn,ack,fin,rst}, and the response-kind enum.
- Sub-module tcp_conn_slot: one per slot via generate. Holds state, rcv_nxt, snd_nxt and flush counter; computes next state and response request.
- Top level: slot decode, rx/cmd arbitration, tx register.

Test Plan:
- Handshake, slot 2: OPEN; SYN seq=100 -> tx SYN|ACK seq=0x1200_0000 ack=101. ACK ack_num=0x1200_0001 -> conn_state[2]=3, no tx.
- Data: seq=101 len=50 -> ACK ack=151. Then seq=300 len=10 -> dup ACK ack=151; rcv_nxt unchanged.
- Close: FIN seq=151 len=0 -> FIN|ACK seq=0x1200_0001 ack=152. State 4 for exactly 8 cycles, then 1 (AUTO_RELISTEN=1); with AUTO_RELISTEN=0, ends at 0.
- Wrap: SYN seq=0xFFFF_FFFF -> ack=0. After the handshake, data seq=0 len=4 -> ack=4.
- Backpressure: tx_ready=0 with two queued segments -> rx_ready=0 after the first; tx fields stable; second response appears the cycle after tx_ready=1.
- RST in ESTABLISHED -> state 5 one cycle, then 1, no tx. Assert rst mid-SYN_RCVD -> all slots 0 and tx_valid 0 immediately.
